// File: rtl/systolic_drain.sv
// Output collector for an NxN systolic array: re-aligns the diagonal bottom-row
// wavefront into whole rows, saturates them and queues them for a valid/ready consumer.
module systolic_drain #(
  parameter int N     = 4,
  parameter int SUM_W = 24,
  parameter int OUT_W = 24,
  parameter int DEPTH = 4,
  parameter int ROWS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N*SUM_W-1:0]       col_sum,
  input  logic                     wave_vld,
  output logic [N*OUT_W-1:0]       out_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  function automatic logic [OUT_W-1:0] sat_elem(input logic [SUM_W-1:0] v);
    if ((v >> OUT_W) != '0) begin
      sat_elem = '1;
    end else begin
      sat_elem = v[OUT_W-1:0];
    end
  endfunction

  logic [N-2:0]         vld_q;
  logic [N*SUM_W-1:0]   aligned_s;
  logic [N*OUT_W-1:0]   sat_row_s;
  logic                 row_vld_s;

  // Valid pipe tracks the head of each wavefront until its last column arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= wave_vld;
      for (int k = 1; k < N - 1; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  assign row_vld_s = vld_q[N-2];

  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_pass
      assign aligned_s[j*SUM_W +: SUM_W] = col_sum[j*SUM_W +: SUM_W];
    end else begin : g_dly
      logic [SUM_W-1:0] dly_q [D];
      // Free-running skew line; validity comes only from the valid pipe.
      always_ff @(posedge clk) begin
        dly_q[0] <= col_sum[j*SUM_W +: SUM_W];
        for (int k = 1; k < D; k++) begin
          dly_q[k] <= dly_q[k-1];
        end
      end
      assign aligned_s[j*SUM_W +: SUM_W] = dly_q[D-1];
    end
  end

  // Saturate each aligned element before it enters the buffer.
  always_comb begin
    sat_row_s = '0;
    for (int j = 0; j < N; j++) begin
      sat_row_s[j*OUT_W +: OUT_W] = sat_elem(aligned_s[j*SUM_W +: SUM_W]);
    end
  end

  logic [N*OUT_W-1:0] mem_q     [DEPTH];
  logic [IDX_W-1:0]   idx_mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     fill_q, fill_d;
  logic [IDX_W-1:0]   row_idx_q, row_idx_d;
  logic               ovf_q, ovf_d;
  logic               pop_s, push_s, drop_s, full_s;

  // A full buffer still accepts a row when the consumer frees a slot in the same cycle.
  always_comb begin
    pop_s     = (fill_q != '0) && out_ready;
    full_s    = (fill_q == FULL_CNT);
    push_s    = row_vld_s && (!full_s || pop_s);
    drop_s    = row_vld_s && full_s && !pop_s;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    row_idx_d = row_idx_q;
    fill_d    = fill_q;
    ovf_d     = ovf_q;
    if (push_s) begin
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      row_idx_d = (row_idx_q == LAST_IDX) ? '0 : row_idx_q + IDX_W'(1);
    end else begin
      wr_ptr_d  = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + (PTR_W + 1)'(1);
      2'b01:   fill_d = fill_q - (PTR_W + 1)'(1);
      default: fill_d = fill_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state of the row buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      row_idx_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      row_idx_q <= row_idx_d;
      ovf_q     <= ovf_d;
    end
  end

  // Row storage carries the batch index of each row alongside its data.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q]     <= sat_row_s;
      idx_mem_q[wr_ptr_q] <= row_idx_q;
    end
  end

  assign out_valid = (fill_q != '0);
  assign out_row   = mem_q[rd_ptr_q];
  assign out_last  = out_valid && (idx_mem_q[rd_ptr_q] == LAST_IDX);
  assign ovf       = ovf_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: table of saturation vectors plus directed and random
// wavefront traffic checked against a queue-based row model.
module tb_systolic_drain;
  localparam int N = 4, SUM_W = 24, OUT_W = 16, DEPTH = 4, ROWS = 4;
  localparam int FW = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*SUM_W-1:0] col_sum;
  logic               wave_vld, out_ready, ovf_clr;
  logic [N*OUT_W-1:0] out_row;
  logic               out_valid, out_last, ovf;
  logic [FW-1:0]      fill;

  systolic_drain #(.N(N), .SUM_W(SUM_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .col_sum(col_sum), .wave_vld(wave_vld),
    .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .ovf(ovf), .ovf_clr(ovf_clr), .fill(fill)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { logic vld; logic [N*SUM_W-1:0] row; } launch_t;
  typedef struct { logic [N*OUT_W-1:0] row; logic last; } exp_t;
  typedef struct { logic [SUM_W-1:0] val; logic [OUT_W-1:0] exp; } sat_vec_t;

  launch_t hist [N];
  exp_t    q [$];
  int      m_idx;
  logic    m_ovf;
  sat_vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*OUT_W-1:0] model_sat(input logic [N*SUM_W-1:0] r);
    logic [N*OUT_W-1:0] res;
    longint unsigned v, mx;
    mx = (longint'(1) << OUT_W) - 1;
    for (int j = 0; j < N; j++) begin
      v = r[j*SUM_W +: SUM_W];
      res[j*OUT_W +: OUT_W] = (v > mx) ? OUT_W'(mx) : OUT_W'(v);
    end
    return res;
  endfunction

  function automatic logic [N*SUM_W-1:0] seq_row(input int base, input int step);
    logic [N*SUM_W-1:0] r;
    for (int j = 0; j < N; j++) r[j*SUM_W +: SUM_W] = SUM_W'(base + j * step);
    return r;
  endfunction

  task automatic compare_state();
    chk("out_valid", out_valid, q.size() != 0);
    chk("fill", fill, q.size());
    chk("ovf", ovf, m_ovf);
    if (q.size() != 0) begin
      chk("out_row", out_row, q[0].row);
      chk("out_last", out_last, q[0].last);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_idx = 0;
    m_ovf = 1'b0;
    for (int k = 0; k < N; k++) begin
      hist[k].vld = 1'b0;
      hist[k].row = '0;
    end
  endtask

  // One clock cycle: check current outputs, drive inputs, advance the model.
  task automatic cyc(input logic vld, input logic [N*SUM_W-1:0] row, input logic rdy, input logic clr);
    logic pop, full;
    compare_state();
    for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0].vld = vld;
    hist[0].row = row;
    for (int j = 0; j < N; j++)
      col_sum[j*SUM_W +: SUM_W] = hist[j].vld ? hist[j].row[j*SUM_W +: SUM_W] : SUM_W'($urandom);
    wave_vld  = vld;
    out_ready = rdy;
    ovf_clr   = clr;
    pop  = (q.size() != 0) && rdy;
    full = (q.size() == DEPTH);
    if (pop) void'(q.pop_front());
    if (hist[N-1].vld && (!full || pop)) begin
      q.push_back('{row: model_sat(hist[N-1].row), last: (m_idx == ROWS - 1)});
      m_idx = (m_idx + 1) % ROWS;
      if (clr) m_ovf = 1'b0;
    end else if (hist[N-1].vld) begin
      m_ovf = 1'b1;
    end else if (clr) begin
      m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, rdy, 1'b0);
  endtask

  initial begin
    logic [N*SUM_W-1:0] rr;
    int lat;

    tbl[0] = '{val: 24'h012345, exp: 16'hFFFF};
    tbl[1] = '{val: 24'h00ABCD, exp: 16'hABCD};
    tbl[2] = '{val: 24'h00FFFF, exp: 16'hFFFF};
    tbl[3] = '{val: 24'h010000, exp: 16'hFFFF};
    tbl[4] = '{val: 24'h000000, exp: 16'h0000};
    tbl[5] = '{val: 24'hFFFFFF, exp: 16'hFFFF};

    rst = 1'b0; wave_vld = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0; col_sum = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    compare_state();
    rst = 1'b1;

    // Single row, then drain.
    idle(2, 1'b1);
    cyc(1'b1, seq_row(1, 1), 1'b1, 1'b0);
    idle(6, 1'b1);

    // Streaming 8 rows, row r column j = 16r+j.
    for (int r = 0; r < 8; r++) cyc(1'b1, seq_row(16 * r, 1), 1'b1, 1'b0);
    idle(6, 1'b1);

    // Overflow: 6 rows into a stalled buffer.
    for (int r = 0; r < 6; r++) cyc(1'b1, seq_row(100 + 10 * r, 1), 1'b0, 1'b0);
    idle(4, 1'b0);
    chk("ovf_set", ovf, 1'b1);
    chk("fill_full", fill, DEPTH);
    idle(6, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("ovf_cleared", ovf, 1'b0);

    // Full buffer with simultaneous push and pop.
    for (int r = 0; r < 4; r++) cyc(1'b1, seq_row(200 + 10 * r, 1), 1'b0, 1'b0);
    idle(3, 1'b0);
    cyc(1'b1, seq_row(300, 1), 1'b0, 1'b0);
    idle(N - 2, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("fill_stays_full", fill, DEPTH);
    chk("no_ovf_push_pop", ovf, 1'b0);
    idle(6, 1'b1);

    // Saturation vectors with explicit latency check.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, {N{tbl[i].val}}, 1'b1, 1'b0);
      lat = 1;
      while (!out_valid && lat < 10) begin
        cyc(1'b0, '0, 1'b1, 1'b0);
        lat++;
      end
      chk("latency", lat, N);
      chk("sat_row", out_row, {N{tbl[i].exp}});
      idle(2, 1'b1);
    end

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < N; j++)
        rr[j*SUM_W +: SUM_W] = $urandom_range(0, 1) ? SUM_W'($urandom) : SUM_W'($urandom_range(0, 65535));
      cyc(1'($urandom_range(0, 1)), rr, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    idle(8, 1'b1);

    // Reset mid-operation: 2 rows buffered, a third mid-wavefront.
    cyc(1'b0, '0, 1'b1, 1'b1);
    for (int r = 0; r < 2; r++) cyc(1'b1, seq_row(400 + 10 * r, 1), 1'b0, 1'b0);
    idle(3, 1'b0);
    cyc(1'b1, seq_row(1, 1), 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("fill_before_rst", fill, 2);
    #2;
    rst = 1'b0;
    wave_vld = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_fill", fill, 0);
    chk("rst_ovf", ovf, 1'b0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int r = 0; r < ROWS; r++) cyc(1'b1, seq_row(500 + 10 * r, 1), 1'b1, 1'b0);
    idle(8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
